// File: rtl/bcd2bin_seq_pkg.sv
// Shared constants for the sequential BCD-to-binary converter:
// digit count, result width, iteration count and FSM state encoding.
package bcd_pkg;

  // Number of BCD digits accepted per conversion.
  localparam int NDIG = 5;

  // Minimum binary width that holds 10**NDIG-1 (99999 needs 17 bits).
  localparam int BW = 17;

  // Width of the packed BCD register.
  localparam int BCDW = 4 * NDIG;

  // One reverse double-dabble step per result bit.
  localparam int NITER = BW;

  // Iteration counter width; must hold NITER-1.
  localparam int CW = 5;

  // Largest value a legal conversion can produce.
  localparam int unsigned MAX_BIN = 99999;

  // FSM state encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // A BCD nibble is illegal when it encodes a value above nine.
  function automatic logic digit_bad(input logic [3:0] digit);
    return (digit > 4'd9);
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Request/response bundle between a requester and the BCD-to-binary converter.
interface bcd2bin_seq_if;
  import bcd_pkg::*;

  logic          start;
  logic [3:0]    D5_in;
  logic [3:0]    D4_in;
  logic [3:0]    D3_in;
  logic [3:0]    D2_in;
  logic [3:0]    D1_in;
  logic          busy;
  logic          done;
  logic          err;
  logic [BW-1:0] bin_out;

  // Requester side: issues start with the digits, observes the result.
  modport master (
    output start, D5_in, D4_in, D3_in, D2_in, D1_in,
    input  busy, done, err, bin_out
  );

  // Converter side.
  modport slave (
    input  start, D5_in, D4_in, D3_in, D2_in, D1_in,
    output busy, done, err, bin_out
  );

endinterface

// File: rtl/bcd2bin_seq_digit_adj.sv
// One-digit correction for reverse double dabble: after a right shift a
// nibble that reads 8 or more has received a carried-in "8" that is really
// worth 5 in decimal, so 3 is taken away.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Subtract 3 from any nibble at or above 8, pass the rest through.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd8) begin
      digit_o = digit_i - 4'd3;
    end
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble.
// A start in IDLE captures five BCD digits; SHIFT then runs one shift/adjust
// step per clock for BW clocks and publishes the binary result with a
// one-cycle done pulse. Illegal digits are rejected on the capture edge.
module bcd2bin_seq #(
  parameter int NDIG = bcd_pkg::NDIG,
  parameter int BW   = bcd_pkg::BW
) (
  input  logic                sysclk,
  input  logic                rst_n,
  bcd2bin_seq_if.slave        bus
);
  import bcd_pkg::*;

  localparam int DW = 4 * NDIG;

  logic [0:0]          state_q, state_d;
  logic [DW-1:0]       bcd_q, bcd_d;
  logic [BW-1:0]       bin_q, bin_d;
  logic [BW-1:0]       bin_out_q, bin_out_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [DW-1:0]       bcd_in;
  logic                any_bad;
  logic [DW+BW-1:0]    shifted;
  logic [DW-1:0]       bcd_adj;
  logic [BW-1:0]       bin_step;
  logic                last_step;

  assign bcd_in = {bus.D5_in, bus.D4_in, bus.D3_in, bus.D2_in, bus.D1_in};

  // Flag the request when any incoming nibble is not a decimal digit.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (digit_bad(bcd_in[4*i +: 4])) begin
        any_bad = 1'b1;
      end
    end
  end

  // Shift the combined {BCD, binary} register right; the BCD LSB falls into
  // the binary MSB.
  always_comb begin
    shifted  = {bcd_q, bin_q} >> 1;
    bin_step = shifted[BW-1:0];
  end

  // Correct each shifted BCD digit independently.
  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (shifted[BW + 4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  assign last_step = (cnt_q == CW'(NITER - 1));

  // Next-state and output logic for the IDLE/SHIFT controller.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    bin_out_d = bin_out_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (any_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            busy_d = 1'b0;
          end else begin
            bcd_d   = bcd_in;
            bin_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = bin_step;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          bin_out_d = bin_step;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      bin_out_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      bin_out_q <= bin_out_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.bin_out = bin_out_q;

  // A published result can never exceed the largest five-digit decimal.
  a_bin_range : assert property (@(posedge sysclk) disable iff (!rst_n)
    bin_out_q <= BW'(MAX_BIN));

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Scoreboard testbench for bcd2bin_seq: the driver predicts each result with
// decimal arithmetic and queues it; a monitor pops and compares on done.
module tb_bcd2bin_seq;
  import bcd_pkg::*;

  typedef struct {
    logic        err;
    int unsigned value;
    longint      due;
  } exp_t;

  logic   sysclk = 1'b0;
  logic   rst_n  = 1'b1;
  longint edge_cnt = 0;
  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int unsigned model_last = 0;

  bcd2bin_seq_if bus ();

  bcd2bin_seq dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) edge_cnt <= edge_cnt + 1;

  function automatic void check_output(input string name, input logic [63:0] act,
                                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge sysclk) begin : monitor
    exp_t e;
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_done at edge %0d", edge_cnt);
      end else begin
        e = sb.pop_front();
        check_output("err", 64'(bus.err), 64'(e.err));
        check_output("bin_out", 64'(bus.bin_out), 64'(e.value));
        check_output("done_latency", 64'(edge_cnt), 64'(e.due));
      end
    end
  end

  // Drive a request (caller is just past a falling edge) and queue its result.
  task automatic apply_stimulus(input int d5, input int d4, input int d3,
                                input int d2, input int d1, output bit is_err);
    exp_t e;
    bus.D5_in = 4'(d5);
    bus.D4_in = 4'(d4);
    bus.D3_in = 4'(d3);
    bus.D2_in = 4'(d2);
    bus.D1_in = 4'(d1);
    bus.start = 1'b1;
    e.err = (d5 > 9) || (d4 > 9) || (d3 > 9) || (d2 > 9) || (d1 > 9);
    if (e.err) begin
      e.value = model_last;
      e.due   = edge_cnt + 1;
    end else begin
      e.value    = d5 * 10000 + d4 * 1000 + d3 * 100 + d2 * 10 + d1;
      model_last = e.value;
      e.due      = edge_cnt + 1 + NITER;
    end
    is_err = e.err;
    sb.push_back(e);
  endtask

  // Wait (bounded) for done; optionally scramble digits or inject a stray start.
  task automatic wait_done(input bit scramble, input int inject_at, input int exp_busy);
    int busy_cycles = 0;
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge sysclk);
      bus.start = (i == inject_at) ? 1'b1 : 1'b0;
      if (scramble) begin
        bus.D5_in = 4'($urandom_range(0, 15));
        bus.D4_in = 4'($urandom_range(0, 15));
        bus.D3_in = 4'($urandom_range(0, 15));
        bus.D2_in = 4'($urandom_range(0, 15));
        bus.D1_in = 4'($urandom_range(0, 15));
      end
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.done === 1'b1) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 40 cycles");
    end
    check_output("busy_cycles", 64'(busy_cycles), 64'(exp_busy));
  endtask

  initial begin
    bit e;
    int d[5];
    bus.start = 1'b0;
    bus.D5_in = '0;
    bus.D4_in = '0;
    bus.D3_in = '0;
    bus.D2_in = '0;
    bus.D1_in = '0;

    #2 rst_n = 1'b0;
    #1;
    check_output("reset_busy", 64'(bus.busy), 64'd0);
    check_output("reset_done", 64'(bus.done), 64'd0);
    check_output("reset_err", 64'(bus.err), 64'd0);
    check_output("reset_bin_out", 64'(bus.bin_out), 64'd0);
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);

    $display("[TB] all nines");
    apply_stimulus(9, 9, 9, 9, 9, e);
    wait_done(0, -1, 17);

    $display("[TB] zero then back-to-back 12345");
    @(negedge sysclk);
    apply_stimulus(0, 0, 0, 0, 0, e);
    wait_done(0, -1, 17);
    apply_stimulus(1, 2, 3, 4, 5, e);
    wait_done(0, -1, 17);

    $display("[TB] 40960 with stray start during shift");
    @(negedge sysclk);
    apply_stimulus(4, 0, 9, 6, 0, e);
    wait_done(0, 4, 17);

    $display("[TB] illegal digit keeps previous result");
    @(negedge sysclk);
    apply_stimulus(1, 2, 10, 3, 4, e);
    wait_done(0, -1, 0);

    $display("[TB] digits scrambled during shift");
    apply_stimulus(6, 5, 5, 3, 5, e);
    wait_done(1, -1, 17);

    $display("[TB] randomized requests");
    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < 5; k++) d[k] = int'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) d[$urandom_range(0, 4)] = int'($urandom_range(10, 15));
      if ($urandom_range(0, 1) == 1) @(negedge sysclk);
      apply_stimulus(d[0], d[1], d[2], d[3], d[4], e);
      wait_done(n[0], -1, e ? 0 : 17);
    end

    $display("[TB] reset during conversion");
    @(negedge sysclk);
    apply_stimulus(5, 4, 3, 2, 1, e);
    @(negedge sysclk);
    bus.start = 1'b0;
    repeat (8) @(negedge sysclk);
    #2 rst_n = 1'b0;
    sb.delete();
    model_last = 0;
    #1;
    check_output("abort_busy", 64'(bus.busy), 64'd0);
    check_output("abort_done", 64'(bus.done), 64'd0);
    check_output("abort_err", 64'(bus.err), 64'd0);
    check_output("abort_bin_out", 64'(bus.bin_out), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge sysclk);
      check_output("in_reset_done", 64'(bus.done), 64'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);
    apply_stimulus(0, 0, 0, 0, 7, e);
    wait_done(0, -1, 17);

    repeat (3) @(negedge sysclk);
    check_output("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
